// File: rtl/db_pkg.sv
// -----------------------------------------------------------------------------
// db_pkg -- shared definitions for the pushbutton debounce timer.
//   db_state_t    : 2-bit FSM state encoding (IDLE, COUNT, DONE, RELWAIT)
//   DB_CYCLES_DEF : default debounce window length in clk cycles (20 ms @ 50 MHz)
//   CNT_W_DEF     : default window counter width
//   st_busy()     : true whenever the FSM has left IDLE
// -----------------------------------------------------------------------------
package db_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    DONE    = 2'd2,
    RELWAIT = 2'd3
  } db_state_t;

  localparam int DB_CYCLES_DEF = 1000000;
  localparam int CNT_W_DEF     = 20;

  function automatic logic st_busy(input db_state_t s);
    return (s != IDLE);
  endfunction

endpackage

// File: rtl/btn_db_tmr_if.sv
// -----------------------------------------------------------------------------
// btn_db_tmr_if -- handshake between the stopwatch controller and the debounce
// timer.
//   strt_pls : controller -> timer, one-cycle request to open a window
//   db_done  : timer -> controller, one-cycle window-complete response
//   busy     : timer -> controller, high while the timer FSM is not IDLE
//   ss_btn   : timer -> controller, one-cycle start/stop press event
//   c_btn    : timer -> controller, synchronized clear level
// Modports: master = controller side, slave = timer side.
// -----------------------------------------------------------------------------
interface btn_db_tmr_if;

  logic strt_pls;
  logic db_done;
  logic busy;
  logic ss_btn;
  logic c_btn;

  modport master (
    output strt_pls,
    input  db_done,
    input  busy,
    input  ss_btn,
    input  c_btn
  );

  modport slave (
    input  strt_pls,
    output db_done,
    output busy,
    output ss_btn,
    output c_btn
  );

endinterface

// File: rtl/btn_sync.sv
// -----------------------------------------------------------------------------
// btn_sync -- 2-flop synchronizer for one asynchronous pushbutton, plus a
// previous-value flop for rising-edge detection.
//   clk  : clock (rising edge)
//   rst  : asynchronous active-low reset
//   raw  : asynchronous button input
//   lvl  : synchronized level (2-cycle latency)
//   rise : one-cycle pulse on a synchronized 0->1 transition
// -----------------------------------------------------------------------------
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic rise
);

  logic lvl_p0, lvl_p1, lvl_p2;
  logic vld_p0, vld_p1, vld_p2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lvl_p0 <= 1'b0;
      lvl_p1 <= 1'b0;
      lvl_p2 <= 1'b0;
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      // stage 0: metastability catch
      lvl_p0 <= raw;
      vld_p0 <= 1'b1;
      // stage 1: synchronized level
      lvl_p1 <= lvl_p0;
      vld_p1 <= vld_p0;
      // stage 2: previous synchronized level for edge detection
      lvl_p2 <= lvl_p1;
      vld_p2 <= vld_p1;
    end
  end

  assign lvl = lvl_p1;
  // The flops all leave reset at 0, so a button held through reset would
  // look like a fresh 0->1 edge; the edge is only trusted once both the
  // current and previous levels come from real post-reset samples.
  assign rise = lvl_p1 & ~lvl_p2 & vld_p2;

endmodule

// File: rtl/btn_db_tmr.sv
// -----------------------------------------------------------------------------
// btn_db_tmr -- pushbutton synchronizer and debounce window timer for the
// stopwatch controller.
//   Parameters : DB_CYCLES (window length in clk cycles, 1..2^CNT_W-1),
//                CNT_W (window counter width)
//   clk        : clock (rising edge)
//   rst        : asynchronous active-low reset
//   c_raw      : asynchronous clear pushbutton
//   ss_raw     : asynchronous start/stop pushbutton
//   bus        : btn_db_tmr_if.slave (strt_pls in; db_done, busy, ss_btn,
//                c_btn out)
// Build option: define BTN_DB_RETRIG_EN to let strt_pls during COUNT restart
// the window; otherwise it is ignored there.
// -----------------------------------------------------------------------------
module btn_db_tmr
  import db_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           c_raw,
  input  logic           ss_raw,
  btn_db_tmr_if.slave    bus
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ss_lvl, ss_rise;
  logic             c_lvl, c_rise_unused;
  logic             ss_btn_r;

  btn_sync u_sync_c (
    .clk  (clk),
    .rst  (rst),
    .raw  (c_raw),
    .lvl  (c_lvl),
    .rise (c_rise_unused)
  );

  btn_sync u_sync_ss (
    .clk  (clk),
    .rst  (rst),
    .raw  (ss_raw),
    .lvl  (ss_lvl),
    .rise (ss_rise)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      ss_btn_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      // Presses outside IDLE are dropped, not remembered for later.
      ss_btn_r <= ss_rise & (state == IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.strt_pls) begin
          state_nxt = COUNT;
          cnt_nxt   = '0;
        end
      end
      COUNT: begin
`ifdef BTN_DB_RETRIG_EN
        if (bus.strt_pls) begin
          cnt_nxt = '0;
        end else if (cnt == LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`else
        // Counter parks at LAST rather than wrapping.
        if (cnt == LAST) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
`endif
      end
      DONE: begin
        state_nxt = RELWAIT;
      end
      RELWAIT: begin
        // Wait for start/stop to be released so one long press is not
        // re-armed as a second event.
        if (!ss_lvl) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.db_done = (state == DONE);
  assign bus.busy    = st_busy(state);
  assign bus.ss_btn  = ss_btn_r;
  assign bus.c_btn   = c_lvl;

endmodule

// File: tb/tb_btn_db_tmr.sv
// -----------------------------------------------------------------------------
// tb_btn_db_tmr -- self-checking bench for btn_db_tmr (DB_CYCLES=16, CNT_W=5).
// A timestamp-based reference model predicts db_done, busy, ss_btn and c_btn
// every cycle from the recorded input history.
// -----------------------------------------------------------------------------
module tb_btn_db_tmr;

  localparam int DB    = 16;
  localparam int CNT_W = 5;

  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic c_raw  = 1'b0;
  logic ss_raw = 1'b0;

  btn_db_tmr_if bus ();

  btn_db_tmr #(.DB_CYCLES(DB), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .c_raw  (c_raw),
    .ss_raw (ss_raw),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  wire [3:0] obs = {bus.db_done, bus.busy, bus.ss_btn, bus.c_btn};

  int n_pass = 0;
  int n_tot  = 0;

  // Model state: cycle index since reset release, input history per cycle,
  // whether a window is active and the cycle at which it completes.
  int       cyc;
  bit       ss_q[$];
  bit       c_q[$];
  bit       st_q[$];
  bit       m_act;
  int       m_tdone;
  logic [3:0] e_vec;

  function automatic bit hist(input int which, input int i);
    if (i < 0) return 1'b0;
    case (which)
      0:       return ss_q[i];
      1:       return c_q[i];
      default: return st_q[i];
    endcase
  endfunction

  task automatic model_reset();
    ss_q.delete();
    c_q.delete();
    st_q.delete();
    cyc     = 0;
    m_act   = 1'b0;
    m_tdone = -1000;
    e_vec   = 4'b0000;
  endtask

  // Prediction for the cycle just after edge n. Raw inputs reach the
  // synchronized level two edges after being driven; a press event is
  // registered one edge after the synchronized rise.
  task automatic model_update();
    int n;
    bit was_idle, e_ss, e_c, e_done;
    n        = cyc;
    was_idle = !m_act;
    if (!m_act) begin
      if (hist(2, n - 1)) begin
        m_act   = 1'b1;
        m_tdone = n + DB;
      end
    end else if (n - 1 < m_tdone) begin
`ifdef BTN_DB_RETRIG_EN
      if (hist(2, n - 1)) m_tdone = n + DB;
`endif
    end else if (n - 1 > m_tdone) begin
      if (!hist(0, n - 3)) m_act = 1'b0;
    end
    e_ss   = was_idle && (n - 1 >= 3) && hist(0, n - 3) && !hist(0, n - 4);
    e_c    = hist(1, n - 2);
    e_done = m_act && (n == m_tdone);
    e_vec  = {e_done, m_act, e_ss, e_c};
  endtask

  task automatic step(input bit ss, input bit c, input bit st);
    ss_raw       = ss;
    c_raw        = c;
    bus.strt_pls = st;
    ss_q.push_back(ss);
    c_q.push_back(c);
    st_q.push_back(st);
    @(posedge clk);
    #1;
    cyc++;
    model_update();
  endtask

  task automatic test_reset();
    bus.strt_pls = 1'b0;
    #2 rst = 1'b0;
    #1;
    n_tot++;
    if (obs !== 4'b0000) $display("FAIL reset_async got=%b want=0000", obs);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_tot++;
    if (obs !== 4'b0000) $display("FAIL reset_hold got=%b want=0000", obs);
    else n_pass++;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_tot++;
      if (obs !== e_vec) $display("FAIL reset_idle cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
    end
  endtask

  task automatic test_ss_press();
    int n0, pulses, at;
    pulses = 0;
    at     = -1;
    n0     = cyc;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 1'b0);
      n_tot++;
      if (obs !== e_vec) $display("FAIL ss_press cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
      if (bus.ss_btn) begin
        pulses++;
        at = cyc;
      end
    end
    n_tot++;
    if (pulses !== 1 || at !== n0 + 3)
      $display("FAIL ss_press_timing pulses=%0d at=%0d want 1 at %0d", pulses, at, n0 + 3);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_tot++;
      if (obs !== e_vec) $display("FAIL ss_release cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
    end
  endtask

  task automatic test_window();
    int k, first_done, n_done;
    bit busy_k;
    first_done = -1;
    n_done     = 0;
    step(1'b0, 1'b0, 1'b1);
    k      = cyc;
    busy_k = bus.busy;
    n_tot++;
    if (obs !== e_vec) $display("FAIL window cyc=%0d got=%b want=%b", cyc, obs, e_vec);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_tot++;
      if (obs !== e_vec) $display("FAIL window cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
      if (bus.db_done) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
      end
    end
    n_tot++;
    if (busy_k !== 1'b1 || first_done !== k + DB || n_done !== 1)
      $display("FAIL window_timing busy_k=%0b done_at=%0d count=%0d want 1 at %0d once",
               busy_k, first_done, n_done, k + DB);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int pulses;
    pulses = 0;
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 26; i++) begin
      step((i >= 12) ? 1'b1 : bit'((i / 2) % 2), 1'b0, 1'b0);
      n_tot++;
      if (obs !== e_vec) $display("FAIL bounce cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
      if (bus.ss_btn) pulses++;
    end
    n_tot++;
    if (pulses !== 0 || bus.busy !== 1'b1)
      $display("FAIL bounce_relwait pulses=%0d busy=%0b want 0 pulses busy 1", pulses, bus.busy);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_tot++;
      if (obs !== e_vec) $display("FAIL bounce_rel cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
    end
    n_tot++;
    if (bus.busy !== 1'b0) $display("FAIL bounce_idle busy=%0b want 0", bus.busy);
    else n_pass++;
  endtask

  task automatic test_retrig();
    int k, first_done, want;
    first_done = -1;
    step(1'b0, 1'b0, 1'b1);
    k = cyc;
    for (int i = 0; i < 31; i++) begin
      step(1'b0, 1'b0, (cyc == k + 8));
      n_tot++;
      if (obs !== e_vec) $display("FAIL retrig cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
      if (bus.db_done && first_done < 0) first_done = cyc;
    end
`ifdef BTN_DB_RETRIG_EN
    want = k + 9 + DB;
`else
    want = k + DB;
`endif
    n_tot++;
    if (first_done !== want) $display("FAIL retrig_timing done_at=%0d want=%0d", first_done, want);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int k, dones, pulses;
    dones  = 0;
    pulses = 0;
    step(1'b0, 1'b0, 1'b1);
    k = cyc;
    while (cyc < k + 10) begin
      step((cyc >= k + 3), 1'b0, 1'b0);
      n_tot++;
      if (obs !== e_vec) $display("FAIL rstmid_run cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
    end
    #3 rst = 1'b0;
    #1;
    n_tot++;
    if (obs !== 4'b0000) $display("FAIL rstmid_async got=%b want=0000", obs);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b0, 1'b0);
      n_tot++;
      if (obs !== e_vec) $display("FAIL rstmid_after cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
      if (bus.db_done) dones++;
      if (bus.ss_btn) pulses++;
    end
    n_tot++;
    if (dones !== 0 || pulses !== 0)
      $display("FAIL rstmid_quiet done=%0d ss_btn=%0d want 0 0", dones, pulses);
    else n_pass++;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clear();
    int d, highs, first;
    highs = 0;
    first = -1;
    step(1'b0, 1'b0, 1'b1);
    d = cyc + 3;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, (cyc >= d && cyc < d + 5), 1'b0);
      n_tot++;
      if (obs !== e_vec) $display("FAIL clear cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
      if (bus.c_btn) begin
        highs++;
        if (first < 0) first = cyc;
      end
    end
    n_tot++;
    if (highs !== 5 || first !== d + 2)
      $display("FAIL clear_timing highs=%0d first=%0d want 5 from %0d", highs, first, d + 2);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    n_tot++;
    if (bus.ss_btn !== 1'b1 || bus.busy !== 1'b1)
      $display("FAIL same_cycle ss_btn=%0b busy=%0b want 1 1", bus.ss_btn, bus.busy);
    else n_pass++;
    for (int i = 0; i < 22; i++) begin
      step(1'b0, 1'b0, 1'b0);
      n_tot++;
      if (obs !== e_vec) $display("FAIL same_cycle_run cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit ss, c;
    int ss_hold, c_hold;
    ss      = 1'b0;
    c       = 1'b0;
    ss_hold = 0;
    c_hold  = 0;
    for (int i = 0; i < 800; i++) begin
      if (ss_hold == 0) begin
        ss      = ~ss;
        ss_hold = $urandom_range(1, 30);
      end
      if (c_hold == 0) begin
        c      = ~c;
        c_hold = $urandom_range(1, 12);
      end
      ss_hold--;
      c_hold--;
      step(ss, c, ($urandom_range(0, 15) == 0));
      n_tot++;
      if (obs !== e_vec) $display("FAIL random cyc=%0d got=%b want=%b", cyc, obs, e_vec);
      else n_pass++;
    end
  endtask

  initial begin
    bus.strt_pls = 1'b0;
    test_reset();
    test_ss_press();
    test_window();
    test_bounce();
    test_retrig();
    test_reset_mid();
    test_clear();
    test_same_cycle();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
